output_port_arbiter: RTL and testbench

Round-robin, packet-holding arbiter for one router output port. It shares the output link among five input ports (wormhole switching) and drives the one-hot crossbar select consumed by the output mux. It replaces fixed-priority selection with fair rotation. Once a grant is issued it is held until the tail flit of that packet has crossed the link.

---
 rtl/noc_pkg.sv | 26 ++
 rtl/output_port_arbiter_if.sv | 21 ++
 rtl/output_port_arbiter_rr_pick.sv | 26 ++
 rtl/output_port_arbiter.sv | 111 +++++++++++
 tb/tb_output_port_arbiter.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Shared router definitions: port count, port indices, one-hot selects and
// the output arbiter state encoding.
package noc_pkg;

    localparam int NPORT = 5;

    localparam int PORT_L = 0;
    localparam int PORT_N = 1;
    localparam int PORT_E = 2;
    localparam int PORT_S = 3;
    localparam int PORT_W = 4;

    localparam logic [NPORT-1:0] OH_NONE = 5'b00000;
    localparam logic [NPORT-1:0] OH_L    = 5'b00001;
    localparam logic [NPORT-1:0] OH_N    = 5'b00010;
    localparam logic [NPORT-1:0] OH_E    = 5'b00100;
    localparam logic [NPORT-1:0] OH_S    = 5'b01000;
    localparam logic [NPORT-1:0] OH_W    = 5'b10000;
    localparam logic [NPORT-1:0] OH_ALL  = 5'b11111;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/output_port_arbiter_if.sv
// Handshake bundle between the input ports / link and one output port arbiter.
interface output_port_arbiter_if #(
    parameter int NPORT = 5
) ();
    logic [NPORT-1:0] req;
    logic [NPORT-1:0] tail;
    logic             out_ready;
    logic [NPORT-1:0] grant;
    logic             xfer;
    logic             err_long;

    modport master (
        output req, tail, out_ready,
        input  grant, xfer, err_long
    );

    modport slave (
        input  req, tail, out_ready,
        output grant, xfer, err_long
    );
endinterface

// File: rtl/output_port_arbiter_rr_pick.sv
// Rotate-priority picker: first set request bit at or above ptr, wrapping,
// returned one-hot; all zeros when nothing requests.
module rr_pick #(
    parameter int NPORT = 5,
    parameter int PW    = $clog2(NPORT)
) (
    input  logic [NPORT-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [NPORT-1:0] win
);
    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NPORT; k++) begin
            idx = PW'((int'(ptr) + k) % NPORT);
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/output_port_arbiter.sv
// Round-robin wormhole arbiter for one router output port; the grant is held
// from the head flit until the tail flit (or a forced release) crosses the link.
//
//  state | meaning
//  IDLE  | no owner, grant=0; arbitrate among requests from ptr upward
//  BUSY  | grant held by one input until its tail xfer or MAX_PKT flits
module output_port_arbiter
    import noc_pkg::*;
#(
    parameter int NPORT   = noc_pkg::NPORT,
    parameter int MAX_PKT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    output_port_arbiter_if.slave bus
);
    localparam int PW = $clog2(NPORT);
    localparam int CW = $clog2(MAX_PKT + 1);

    localparam logic [0:0] IDLE = ARB_IDLE;
    localparam logic [0:0] BUSY = ARB_BUSY;

    logic [0:0]       state_q, state_d;
    logic [NPORT-1:0] grant_q, grant_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    flit_cnt_q, flit_cnt_d;
    logic             err_long_q, err_long_d;

    logic [NPORT-1:0] win;
    logic [PW-1:0]    own_idx;
    logic [PW-1:0]    ptr_next;
    logic             xfer;
    logic             tail_hit;
    logic             at_limit;

    rr_pick #(
        .NPORT (NPORT),
        .PW    (PW)
    ) u_pick (
        .req (bus.req),
        .ptr (ptr_q),
        .win (win)
    );

    assign xfer     = bus.out_ready & |(grant_q & bus.req);
    assign tail_hit = |(grant_q & bus.tail);
    assign at_limit = (flit_cnt_q == CW'(MAX_PKT - 1));

    always_comb begin
        own_idx = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (grant_q[i]) own_idx = PW'(i);
        end
        ptr_next = (int'(own_idx) == NPORT - 1) ? '0 : own_idx + 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        flit_cnt_d = flit_cnt_q;
        err_long_d = err_long_q;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    grant_d    = win;
                    flit_cnt_d = '0;
                    state_d    = BUSY;
                end else begin
                    grant_d = '0;
                end
            end
            BUSY: begin
                if (xfer) begin
                    if (flit_cnt_q != CW'(MAX_PKT)) flit_cnt_d = flit_cnt_q + 1'b1;
                    // Tail wins over the length limit: a tail on the last allowed flit is clean.
                    if (tail_hit || at_limit) begin
                        grant_d = '0;
                        state_d = IDLE;
                        ptr_d   = ptr_next;
                        if (!tail_hit) err_long_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            ptr_q      <= '0;
            flit_cnt_q <= '0;
            err_long_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            flit_cnt_q <= flit_cnt_d;
            err_long_q <= err_long_d;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.xfer     = xfer;
    assign bus.err_long = err_long_q;
endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed bench for output_port_arbiter: a default instance (MAX_PKT=16) and a
// MAX_PKT=4 instance share the same stimulus; they differ only on long packets.
module tb_output_port_arbiter;
    import noc_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] req;
    logic [4:0] tail;
    logic       rdy;

    int n_tests = 0;
    int n_fail  = 0;

    output_port_arbiter_if #(.NPORT(5)) if16 ();
    output_port_arbiter_if #(.NPORT(5)) if4 ();

    assign if16.req       = req;
    assign if16.tail      = tail;
    assign if16.out_ready = rdy;
    assign if4.req        = req;
    assign if4.tail       = tail;
    assign if4.out_ready  = rdy;

    output_port_arbiter #(.NPORT(5), .MAX_PKT(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));
    output_port_arbiter #(.NPORT(5), .MAX_PKT(4))  dut4  (.clk(clk), .rst(rst), .bus(if4));

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] req;
        logic [4:0] tail;
        logic       rdy;
        logic       xfer;
        logic [4:0] grant;
    } vec_t;

    vec_t vt[18];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] r, input logic [4:0] t, input logic o);
        req  = r;
        tail = t;
        rdy  = o;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Both instances must agree here: xfer before the edge, grant/err after it.
    task automatic run_vec(input string nm, input logic [4:0] r, input logic [4:0] t,
                           input logic o, input logic xf, input logic [4:0] g);
        set_in(r, t, o);
        check({nm, ".xfer16"}, 32'(if16.xfer), 32'(xf));
        check({nm, ".xfer4"},  32'(if4.xfer),  32'(xf));
        tick();
        check({nm, ".grant16"}, 32'(if16.grant), 32'(g));
        check({nm, ".grant4"},  32'(if4.grant),  32'(g));
        check({nm, ".err16"},   32'(if16.err_long), 32'd0);
        check({nm, ".err4"},    32'(if4.err_long),  32'd0);
    endtask

    task automatic chk_cnt(input string nm, input int exp);
        check({nm, ".cnt16"}, 32'(dut16.flit_cnt_q), 32'(exp));
        check({nm, ".cnt4"},  32'(dut4.flit_cnt_q),  32'(exp));
    endtask

    initial begin
        logic [4:0] one;
        one = OH_L;

        // Fairness: all ports request single-flit packets.
        for (int i = 0; i < 12; i++) begin
            vt[i].req  = OH_ALL;
            vt[i].tail = OH_ALL;
            vt[i].rdy  = 1'b1;
            if (i % 2 == 0) begin
                vt[i].xfer  = 1'b0;
                vt[i].grant = one << ((i / 2) % 5);
            end else begin
                vt[i].xfer  = 1'b1;
                vt[i].grant = OH_NONE;
            end
        end
        // Packet hold: port N (ptr=1) sends 4 flits while everyone requests.
        vt[12] = '{OH_ALL, OH_NONE, 1'b1, 1'b0, OH_N};
        vt[13] = '{OH_ALL, OH_NONE, 1'b1, 1'b1, OH_N};
        vt[14] = '{OH_ALL, OH_NONE, 1'b1, 1'b1, OH_N};
        vt[15] = '{OH_ALL, OH_NONE, 1'b1, 1'b1, OH_N};
        vt[16] = '{OH_ALL, OH_N,    1'b1, 1'b1, OH_NONE};
        vt[17] = '{OH_ALL, OH_NONE, 1'b1, 1'b0, OH_E};

        rst  = 1'b1;
        req  = '0;
        tail = '0;
        rdy  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.grant16", 32'(if16.grant), 32'd0);
        check("rst.grant4",  32'(if4.grant),  32'd0);
        rst = 1'b0;
        #1;
        check("rst.err16", 32'(if16.err_long), 32'd0);
        check("rst.err4",  32'(if4.err_long),  32'd0);
        check("rst.xfer16", 32'(if16.xfer), 32'd0);
        chk_cnt("rst", 0);

        for (int i = 0; i < 18; i++) begin
            run_vec($sformatf("vec%0d", i), vt[i].req, vt[i].tail, vt[i].rdy, vt[i].xfer, vt[i].grant);
        end

        // Back-pressure in the middle of a 2-flit packet on port E.
        run_vec("bp_f1", OH_E, OH_NONE, 1'b1, 1'b1, OH_E);
        chk_cnt("bp_f1", 1);
        for (int i = 0; i < 3; i++) begin
            run_vec("bp_stall", OH_E, OH_NONE, 1'b0, 1'b0, OH_E);
            chk_cnt("bp_stall", 1);
        end
        run_vec("bp_tail", OH_E, OH_E, 1'b1, 1'b1, OH_NONE);
        chk_cnt("bp_tail", 2);

        // Owner bubble: port S drops req for two cycles while others request.
        run_vec("ob_arb", OH_ALL, OH_NONE, 1'b1, 1'b0, OH_S);
        chk_cnt("ob_arb", 0);
        run_vec("ob_f1", OH_ALL, OH_NONE, 1'b1, 1'b1, OH_S);
        for (int i = 0; i < 2; i++) begin
            run_vec("ob_drop", OH_ALL & ~OH_S, OH_NONE, 1'b1, 1'b0, OH_S);
            chk_cnt("ob_drop", 1);
        end
        run_vec("ob_tail", OH_ALL, OH_S, 1'b1, 1'b1, OH_NONE);
        chk_cnt("ob_tail", 2);
        run_vec("ob_next", OH_ALL, OH_NONE, 1'b1, 1'b0, OH_W);

        // Runaway: port S streams with no tail; only the MAX_PKT=4 copy cuts it off.
        run_vec("rw_wtail", OH_ALL, OH_W, 1'b1, 1'b1, OH_NONE);
        run_vec("rw_arb", OH_S, OH_NONE, 1'b1, 1'b0, OH_S);
        for (int i = 0; i < 3; i++) begin
            run_vec("rw_body", OH_S | OH_W, OH_NONE, 1'b1, 1'b1, OH_S);
        end
        chk_cnt("rw_body", 3);
        set_in(OH_S | OH_W, OH_NONE, 1'b1);
        check("rw_f4.xfer16", 32'(if16.xfer), 32'd1);
        check("rw_f4.xfer4",  32'(if4.xfer),  32'd1);
        tick();
        check("rw_f4.grant4",  32'(if4.grant),     32'(OH_NONE));
        check("rw_f4.err4",    32'(if4.err_long),  32'd1);
        check("rw_f4.grant16", 32'(if16.grant),    32'(OH_S));
        check("rw_f4.err16",   32'(if16.err_long), 32'd0);
        set_in(OH_S | OH_W, OH_NONE, 1'b1);
        check("rw_next.xfer4",  32'(if4.xfer),  32'd0);
        check("rw_next.xfer16", 32'(if16.xfer), 32'd1);
        tick();
        check("rw_next.grant4",  32'(if4.grant),    32'(OH_W));
        check("rw_next.err4",    32'(if4.err_long), 32'd1);
        check("rw_next.grant16", 32'(if16.grant),   32'(OH_S));
        tick();
        check("rw_sticky.err4", 32'(if4.err_long), 32'd1);

        // Asynchronous reset, then reset while port E owns the link mid-packet.
        rst = 1'b1;
        #1;
        check("rst2.grant16", 32'(if16.grant),   32'd0);
        check("rst2.grant4",  32'(if4.grant),    32'd0);
        check("rst2.err4",    32'(if4.err_long), 32'd0);
        tick();
        rst = 1'b0;
        run_vec("rst_arb", OH_E, OH_NONE, 1'b1, 1'b0, OH_E);
        set_in(OH_E, OH_NONE, 1'b1);
        check("rst_mid.xfer16", 32'(if16.xfer), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid.grant16", 32'(if16.grant), 32'd0);
        check("rst_mid.grant4",  32'(if4.grant),  32'd0);
        check("rst_mid.xfer4",   32'(if4.xfer),   32'd0);
        tick();
        rst = 1'b0;
        chk_cnt("rst_mid", 0);
        run_vec("rst_ptr0", OH_ALL, OH_ALL, 1'b1, 1'b0, OH_L);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
